// File: rtl/uart_pkt_pkg.sv
// Shared definitions for the UART packet decoder: framing defaults, FSM state type
// and the saturating error-count helper.
package uart_pkt_pkg;

  localparam logic [7:0] SYNC_BYTE_DEF   = 8'hA5;
  localparam int         MAX_PAYLOAD_DEF = 8;

  typedef enum logic [2:0] {
    ST_HUNT,
    ST_CMD,
    ST_LEN,
    ST_PAYLOAD,
    ST_CHECK
  } state_e;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/pkt_payload_buf.sv
// Payload staging array plus the held output snapshot; commit copies staging with
// bytes at or beyond the committed length forced to zero. One-cycle commit, no backpressure.
module pkt_payload_buf import uart_pkt_pkg::*; #(
  parameter int MAX_PAYLOAD = MAX_PAYLOAD_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en_i,
  input  logic [3:0]               wr_idx_i,
  input  logic [7:0]               wr_dat_i,
  input  logic                     clear_i,
  input  logic                     commit_i,
  input  logic [3:0]               commit_len_i,
  output logic [8*MAX_PAYLOAD-1:0] payload_o
);

  logic [7:0]               stage_q [MAX_PAYLOAD];
  logic [8*MAX_PAYLOAD-1:0] payload_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      payload_q <= '0;
      for (int i = 0; i < MAX_PAYLOAD; i++) stage_q[i] <= 8'h00;
    end else begin
      for (int i = 0; i < MAX_PAYLOAD; i++) begin
        if (clear_i)
          stage_q[i] <= 8'h00;
        else if (wr_en_i && wr_idx_i == 4'(i))
          stage_q[i] <= wr_dat_i;
      end
      // Staging may hold stale bytes from a longer aborted packet; mask them here.
      if (commit_i) begin
        for (int i = 0; i < MAX_PAYLOAD; i++)
          payload_q[8*i +: 8] <= (4'(i) < commit_len_i) ? stage_q[i] : 8'h00;
      end
    end
  end

  assign payload_o = payload_q;

endmodule

// File: rtl/uart_packet_decoder.sv
// Frames UART bytes into SYNC/CMD/LEN/payload/CK packets; outputs and error strobes are
// registered one cycle after the causing byte or idle strobe. No backpressure: every byte is consumed.
module uart_packet_decoder import uart_pkt_pkg::*; #(
  parameter int         MAX_PAYLOAD = MAX_PAYLOAD_DEF,
  parameter logic [7:0] SYNC_BYTE   = SYNC_BYTE_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     RxD_data_ready,
  input  logic [7:0]               RxD_data,
  input  logic                     RxD_endofpacket,
  output logic                     pkt_valid,
  output logic [7:0]               pkt_cmd,
  output logic [3:0]               pkt_len,
  output logic [8*MAX_PAYLOAD-1:0] pkt_payload,
  output logic                     err_checksum,
  output logic                     err_length,
  output logic                     err_timeout,
  output logic [7:0]               err_count
);

  localparam logic [7:0] MAX_LEN = 8'(MAX_PAYLOAD);

  state_e     state_q;
  logic [7:0] acc_q;
  logic [7:0] cmd_q;
  logic [3:0] len_q;
  logic [3:0] idx_q;
  logic       pkt_valid_q;
  logic [7:0] pkt_cmd_q;
  logic [3:0] pkt_len_q;
  logic       err_checksum_q;
  logic       err_length_q;
  logic       err_timeout_q;
  logic [7:0] err_count_q;

  logic abort;
  logic byte_vld;
  logic ck_ok;
  logic buf_wr;
  logic buf_clear;
  logic buf_commit;

  // An idle strobe mid-packet beats any byte arriving in the same cycle.
  assign abort      = RxD_endofpacket && (state_q != ST_HUNT);
  assign byte_vld   = RxD_data_ready && !abort;
  assign ck_ok      = (RxD_data == acc_q);
  assign buf_wr     = byte_vld && (state_q == ST_PAYLOAD);
  assign buf_clear  = byte_vld && (state_q == ST_HUNT) && (RxD_data == SYNC_BYTE);
  assign buf_commit = byte_vld && (state_q == ST_CHECK) && ck_ok;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_HUNT;
      acc_q          <= 8'h00;
      cmd_q          <= 8'h00;
      len_q          <= 4'h0;
      idx_q          <= 4'h0;
      pkt_valid_q    <= 1'b0;
      pkt_cmd_q      <= 8'h00;
      pkt_len_q      <= 4'h0;
      err_checksum_q <= 1'b0;
      err_length_q   <= 1'b0;
      err_timeout_q  <= 1'b0;
      err_count_q    <= 8'h00;
    end else begin
      pkt_valid_q    <= 1'b0;
      err_checksum_q <= 1'b0;
      err_length_q   <= 1'b0;
      err_timeout_q  <= 1'b0;
      if (abort) begin
        state_q       <= ST_HUNT;
        err_timeout_q <= 1'b1;
        err_count_q   <= sat_inc(err_count_q);
      end else if (RxD_data_ready) begin
        unique case (state_q)
          ST_HUNT: begin
            if (RxD_data == SYNC_BYTE) begin
              state_q <= ST_CMD;
              acc_q   <= 8'h00;
            end
          end
          ST_CMD: begin
            cmd_q   <= RxD_data;
            acc_q   <= acc_q ^ RxD_data;
            state_q <= ST_LEN;
          end
          ST_LEN: begin
            if (RxD_data > MAX_LEN) begin
              state_q      <= ST_HUNT;
              err_length_q <= 1'b1;
              err_count_q  <= sat_inc(err_count_q);
            end else begin
              len_q   <= RxD_data[3:0];
              acc_q   <= acc_q ^ RxD_data;
              idx_q   <= 4'h0;
              state_q <= (RxD_data == 8'h00) ? ST_CHECK : ST_PAYLOAD;
            end
          end
          ST_PAYLOAD: begin
            acc_q <= acc_q ^ RxD_data;
            idx_q <= idx_q + 4'd1;
            if (idx_q == len_q - 4'd1) state_q <= ST_CHECK;
          end
          ST_CHECK: begin
            state_q <= ST_HUNT;
            if (ck_ok) begin
              pkt_valid_q <= 1'b1;
              pkt_cmd_q   <= cmd_q;
              pkt_len_q   <= len_q;
            end else begin
              err_checksum_q <= 1'b1;
              err_count_q    <= sat_inc(err_count_q);
            end
          end
          default: state_q <= ST_HUNT;
        endcase
      end
    end
  end

  pkt_payload_buf #(.MAX_PAYLOAD(MAX_PAYLOAD)) u_buf (
    .clk          (clk),
    .rst          (rst),
    .wr_en_i      (buf_wr),
    .wr_idx_i     (idx_q),
    .wr_dat_i     (RxD_data),
    .clear_i      (buf_clear),
    .commit_i     (buf_commit),
    .commit_len_i (len_q),
    .payload_o    (pkt_payload)
  );

  assign pkt_valid    = pkt_valid_q;
  assign pkt_cmd      = pkt_cmd_q;
  assign pkt_len      = pkt_len_q;
  assign err_checksum = err_checksum_q;
  assign err_length   = err_length_q;
  assign err_timeout  = err_timeout_q;
  assign err_count    = err_count_q;

endmodule

// File: tb/tb_uart_packet_decoder.sv
// Directed bench for uart_packet_decoder: a queue-based packet model checked every cycle,
// plus literal expectations taken from hand-worked packets.
module tb_uart_packet_decoder;

  localparam int         MAXP = 8;
  localparam logic [7:0] SYNC = 8'hA5;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              RxD_data_ready = 1'b0;
  logic [7:0]        RxD_data = 8'h00;
  logic              RxD_endofpacket = 1'b0;
  logic              pkt_valid;
  logic [7:0]        pkt_cmd;
  logic [3:0]        pkt_len;
  logic [8*MAXP-1:0] pkt_payload;
  logic              err_checksum;
  logic              err_length;
  logic              err_timeout;
  logic [7:0]        err_count;

  int checks = 0;
  int failures = 0;
  int n_valid = 0, n_ck = 0, n_len = 0, n_to = 0;

  uart_packet_decoder #(.MAX_PAYLOAD(MAXP), .SYNC_BYTE(SYNC)) dut (
    .clk             (clk),
    .rst             (rst),
    .RxD_data_ready  (RxD_data_ready),
    .RxD_data        (RxD_data),
    .RxD_endofpacket (RxD_endofpacket),
    .pkt_valid       (pkt_valid),
    .pkt_cmd         (pkt_cmd),
    .pkt_len         (pkt_len),
    .pkt_payload     (pkt_payload),
    .err_checksum    (err_checksum),
    .err_length      (err_length),
    .err_timeout     (err_timeout),
    .err_count       (err_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: buffer every byte after a sync and judge the packet once it is complete.
  logic [7:0]        q[$];
  bit                in_pkt = 0;
  logic              exp_valid = 0, exp_eck = 0, exp_elen = 0, exp_eto = 0;
  logic [7:0]        exp_cmd = 0, exp_cnt = 0;
  logic [3:0]        exp_len = 0;
  logic [8*MAXP-1:0] exp_pay = 0;

  always @(posedge clk or posedge rst) begin
    logic [7:0] x;
    if (rst) begin
      in_pkt = 0; q.delete();
      exp_valid = 0; exp_eck = 0; exp_elen = 0; exp_eto = 0;
      exp_cmd = 0; exp_len = 0; exp_pay = 0; exp_cnt = 0;
    end else begin
      exp_valid = 0; exp_eck = 0; exp_elen = 0; exp_eto = 0;
      if (RxD_endofpacket && in_pkt) begin
        exp_eto = 1; in_pkt = 0;
        if (exp_cnt != 8'hFF) exp_cnt++;
      end else if (RxD_data_ready) begin
        if (!in_pkt) begin
          if (RxD_data == SYNC) begin in_pkt = 1; q.delete(); end
        end else begin
          q.push_back(RxD_data);
          if (q.size() == 2 && int'(q[1]) > MAXP) begin
            exp_elen = 1; in_pkt = 0;
            if (exp_cnt != 8'hFF) exp_cnt++;
          end else if (q.size() >= 2 && q.size() == int'(q[1]) + 3) begin
            x = 8'h00;
            for (int i = 0; i < q.size() - 1; i++) x ^= q[i];
            if (x == q[q.size()-1]) begin
              exp_valid = 1; exp_cmd = q[0]; exp_len = q[1][3:0]; exp_pay = '0;
              for (int i = 0; i < int'(q[1]); i++) exp_pay[8*i +: 8] = q[2+i];
            end else begin
              exp_eck = 1;
              if (exp_cnt != 8'hFF) exp_cnt++;
            end
            in_pkt = 0;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      n_valid += int'(pkt_valid); n_ck += int'(err_checksum);
      n_len += int'(err_length);  n_to += int'(err_timeout);
      chk("cyc_pkt_valid", 64'(pkt_valid), 64'(exp_valid));
      chk("cyc_pkt_cmd", 64'(pkt_cmd), 64'(exp_cmd));
      chk("cyc_pkt_len", 64'(pkt_len), 64'(exp_len));
      chk("cyc_pkt_payload", 64'(pkt_payload), 64'(exp_pay));
      chk("cyc_err_checksum", 64'(err_checksum), 64'(exp_eck));
      chk("cyc_err_length", 64'(err_length), 64'(exp_elen));
      chk("cyc_err_timeout", 64'(err_timeout), 64'(exp_eto));
      chk("cyc_err_count", 64'(err_count), 64'(exp_cnt));
    end
  end

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    RxD_data = b; RxD_data_ready = 1'b1; RxD_endofpacket = 1'b0;
  endtask

  task automatic send_with_eop(input logic [7:0] b);
    @(negedge clk);
    RxD_data = b; RxD_data_ready = 1'b1; RxD_endofpacket = 1'b1;
  endtask

  task automatic eop();
    @(negedge clk);
    RxD_data_ready = 1'b0; RxD_endofpacket = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      RxD_data_ready = 1'b0; RxD_endofpacket = 1'b0;
    end
    #1;
  endtask

  task automatic send_good();
    send(8'hA5); send(8'h01); send(8'h02); send(8'h3C); send(8'h0F); send(8'h30);
  endtask

  int v0, c0, l0, t0;

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    idle(2);
    chk("reset_cmd", 64'(pkt_cmd), 64'h0);
    chk("reset_payload", 64'(pkt_payload), 64'h0);
    chk("reset_err_count", 64'(err_count), 64'h0);

    v0 = n_valid;
    send_good(); idle(2);
    chk("good_valid_pulses", 64'(n_valid - v0), 64'd1);
    chk("good_cmd", 64'(pkt_cmd), 64'h01);
    chk("good_len", 64'(pkt_len), 64'd2);
    chk("good_payload", 64'(pkt_payload), 64'h0F3C);
    chk("good_err_count", 64'(err_count), 64'd0);

    c0 = n_ck;
    send(8'hA5); send(8'h01); send(8'h02); send(8'h3C); send(8'h0F); send(8'h31); idle(2);
    chk("badck_strobes", 64'(n_ck - c0), 64'd1);
    chk("badck_err_count", 64'(err_count), 64'd1);
    chk("badck_held_cmd", 64'(pkt_cmd), 64'h01);
    chk("badck_held_payload", 64'(pkt_payload), 64'h0F3C);

    l0 = n_len;
    send(8'hA5); send(8'h07); send(8'h09); idle(2);
    chk("oversize_strobes", 64'(n_len - l0), 64'd1);
    chk("oversize_err_count", 64'(err_count), 64'd2);
    send(8'hA5); send(8'h07); send(8'h00); send(8'h07); idle(2);
    chk("zero_len_cmd", 64'(pkt_cmd), 64'h07);
    chk("zero_len_len", 64'(pkt_len), 64'd0);
    chk("zero_len_payload", 64'(pkt_payload), 64'h0);

    t0 = n_to;
    send(8'hA5); send(8'h01); send(8'h02); send(8'h3C); eop(); idle(2);
    chk("gap_strobes", 64'(n_to - t0), 64'd1);
    chk("gap_err_count", 64'(err_count), 64'd3);
    send(8'hA5); send(8'h01); send_with_eop(8'h02); idle(2);
    chk("gap_and_byte_err_count", 64'(err_count), 64'd4);
    eop(); idle(2);
    chk("hunt_eop_ignored", 64'(err_count), 64'd4);
    send(8'h00); send_good(); idle(2);
    chk("after_gap_cmd", 64'(pkt_cmd), 64'h01);
    chk("after_gap_payload", 64'(pkt_payload), 64'h0F3C);

    send(8'h00); send(8'hFF); send(8'hA5); send(8'h02); send(8'h01); send(8'hA5); send(8'hA6);
    idle(2);
    chk("embed_cmd", 64'(pkt_cmd), 64'h02);
    chk("embed_len", 64'(pkt_len), 64'd1);
    chk("embed_payload", 64'(pkt_payload), 64'hA5);
    chk("noise_no_errors", 64'(err_count), 64'd4);

    v0 = n_valid;
    send_good(); send(8'hA5); send(8'h07); send(8'h00); send(8'h07); idle(2);
    chk("back_to_back_valids", 64'(n_valid - v0), 64'd2);

    for (int i = 0; i < 300; i++) begin
      send(8'hA5); send(8'h07); send(8'h00); send(8'h00);
    end
    idle(2);
    chk("saturated_err_count", 64'(err_count), 64'd255);

    send(8'hA5); send(8'h03); send(8'h04); send(8'h11); send(8'h22);
    @(negedge clk);
    RxD_data_ready = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    idle(1);
    chk("rst_cmd", 64'(pkt_cmd), 64'h0);
    chk("rst_len", 64'(pkt_len), 64'h0);
    chk("rst_payload", 64'(pkt_payload), 64'h0);
    chk("rst_err_count", 64'(err_count), 64'h0);
    v0 = n_valid;
    send(8'h33); send_good(); idle(2);
    chk("post_rst_valid", 64'(n_valid - v0), 64'd1);
    chk("post_rst_payload", 64'(pkt_payload), 64'h0F3C);
    chk("post_rst_err_count", 64'(err_count), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_packet_decoder.md
# uart_packet_decoder

Frames the byte stream from the UART receiver into checksummed command packets for the instrument controller. It hunts for a sync byte, collects command, length and payload, and verifies an XOR checksum. On success it publishes the packet as one held snapshot with a single-cycle strobe. Malformed, oversize or gap-truncated packets are dropped and counted, and the last good snapshot is never disturbed.

## Interface
- `MAX_PAYLOAD`, default 8: maximum payload bytes per packet (1..15).
- `SYNC_BYTE`, default 8'hA5: packet start marker.

Ports:
- `clk` in 1: system clock, same domain as the receiver.
- `rst` in 1: reset, asynchronous, active-high.
- `RxD_data_ready` in 1: one-cycle strobe; `RxD_data` is valid this cycle.
- `RxD_data` in 8: received byte.
- `RxD_endofpacket` in 1: one-cycle strobe; the line has gone idle.
- `pkt_valid` out 1: one-cycle strobe; a new packet was committed.
- `pkt_cmd` out 8: command byte, held until the next commit.
- `pkt_len` out 4: payload length, held.
- `pkt_payload` out 8*MAX_PAYLOAD: payload, byte 0 in bits [7:0]; bytes at index ≥ `pkt_len` read zero; held.
- `err_checksum` out 1: one-cycle strobe; checksum mismatch.
- `err_length` out 1: one-cycle strobe; len > `MAX_PAYLOAD`.
- `err_timeout` out 1: one-cycle strobe; gap occurred mid-packet.
- `err_count` out 8: saturating count of all errors.

## Operation
- Packet format: `SYNC`, `CMD`, `LEN`, `LEN`×payload, `CK`.
- `CK` = XOR of `CMD`, `LEN` and every payload byte.
- States are HUNT, CMD, LEN, PAYLOAD, CHECK. Transitions occur only on `RxD_data_ready`, except aborts.
- HUNT:
  - byte == `SYNC_BYTE` → CMD, clear accumulator.
  - any other byte is ignored silently.
- CMD: store to staging, accumulate → LEN.
- LEN:
  - value > `MAX_PAYLOAD` → `err_length`, go to HUNT.
  - value == 0 → CHECK.
  - otherwise → PAYLOAD, clear the byte index.
- PAYLOAD: write staging[index], accumulate, increment index. When index reaches LEN−1 → CHECK.
- CHECK:
  - byte == accumulator → commit, go to HUNT.
  - otherwise → `err_checksum`, go to HUNT.
- Commit copies staging into `pkt_cmd`, `pkt_len` and `pkt_payload`, zero-fills bytes ≥ LEN, and pulses `pkt_valid`.
- A sync value inside CMD, LEN, PAYLOAD or CHECK is ordinary data. There is no resync mid-packet.
- `RxD_endofpacket` in any state other than HUNT → `err_timeout`, go to HUNT. In HUNT it is ignored.
- If `RxD_endofpacket` and `RxD_data_ready` arrive in the same cycle outside HUNT, the abort wins and the byte is discarded.
- `err_count` increments by 1 per error strobe and saturates at 255. Only one error can strobe per cycle.
- Reset mid-packet discards the partial packet and clears the held outputs.

## Timing
- Reset values:
  - state HUNT.
  - `pkt_valid`, `err_*` strobes 0.
  - `pkt_cmd`, `pkt_len`, `pkt_payload` 0.
  - `err_count` 0.
- `pkt_valid` and all held outputs change exactly 1 cycle after the `RxD_data_ready` that carries `CK`. Held outputs are stable from that cycle onward.
- Error strobes assert 1 cycle after the offending byte or `RxD_endofpacket` strobe.
- `err_count` updates in the same cycle as its strobe.
- Back-to-back bytes on consecutive cycles are accepted; there is no minimum byte spacing.
- The next `SYNC` may arrive on the cycle immediately after `CK`.

## Structure
- Shared package `uart_pkt_pkg`:
  - `SYNC_BYTE` default.
  - state enum (HUNT, CMD, LEN, PAYLOAD, CHECK).
  - `MAX_PAYLOAD` limit constant.
- One sub-module, `pkt_payload_buf`:
  - staging register array with write-index port.
  - commit/clear control.
  - zero-fill on commit.
  - outputs the flattened payload.
- FSM, checksum accumulator and error counter live in the top level.

## Test plan
- Good packet: bytes A5 01 02 3C 0F 30 → `pkt_valid` ×1, `pkt_cmd`=01, `pkt_len`=2, `pkt_payload`[15:0]=0F3C, upper bytes 0, no errors.
- Bad checksum: A5 01 02 3C 0F 31 → `err_checksum` ×1, `err_count`=1, held outputs keep the previous good packet.
- Oversize: A5 07 09 → `err_length` after byte 09. Then A5 07 00 07 → `pkt_valid`, `pkt_len`=0, payload all 0.
- Gap: A5 01 02 3C, then `RxD_endofpacket` → `err_timeout`, state HUNT. A following good packet decodes correctly.
- Noise and embedded sync: 00 FF A5 02 01 A5 A6 → one packet with cmd 02, payload[7:0]=A5. Leading 00 and FF produce no errors.
- Saturation and reset: 300 bad-checksum packets → `err_count`=255. Asserting `rst` mid-payload clears all outputs, and decoding resumes cleanly after reset.
